// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for cpu_top: fetch/decode/exec/mem/wb sequencing.
// In: clk, rst, start, opcode, alu_zero, mem_ack. Out: datapath enables/selects, halted/fault, state_o, instr_count.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WD_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t          state;
  state_t          nxt;
  logic            retire;
  logic [WD_W-1:0] wd;
  logic            wait_cyc;
  logic            wd_expire;

  logic op_nop, op_add, op_sub, op_and, op_or;
  logic op_addi, op_ld, op_st, op_beq, op_jmp, op_hlt;
  logic op_alu, op_illegal;

  assign op_nop  = (opcode == 4'h0);
  assign op_add  = (opcode == 4'h1);
  assign op_sub  = (opcode == 4'h2);
  assign op_and  = (opcode == 4'h3);
  assign op_or   = (opcode == 4'h4);
  assign op_addi = (opcode == 4'h5);
  assign op_ld   = (opcode == 4'h6);
  assign op_st   = (opcode == 4'h7);
  assign op_beq  = (opcode == 4'h8);
  assign op_jmp  = (opcode == 4'h9);
  assign op_hlt  = (opcode == 4'hF);
  assign op_alu  = op_add | op_sub | op_and | op_or;
  assign op_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);

  // Request is always up in FETCH/MEM, so a wait cycle is simply no ack there.
  assign wait_cyc  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;
  // Expire on the MEM_TIMEOUT-th consecutive wait cycle; an ack then still wins.
  assign wd_expire = wait_cyc && (wd == WD_W'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack)        nxt = S_DECODE;
        else if (wd_expire) nxt = S_FAULT;
      end
      S_DECODE: begin
        if (op_nop || op_jmp) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end else if (op_hlt) begin
          nxt    = S_HALT;
          retire = 1'b1;
        end else if (op_illegal) begin
          nxt = S_FAULT;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_beq) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end else if (op_ld || op_st) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op_st) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end else begin
            nxt = S_WB;
          end
        end else if (wd_expire) begin
          nxt = S_FAULT;
        end
      end
      S_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_HALT:   nxt = S_HALT;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wd          <= '0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (wait_cyc && !wd_expire) wd <= wd + 1'b1;
      else                        wd <= '0;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    alu_op      = 3'b000;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_jmp) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          op_sub, op_beq: alu_op = 3'b001;
          op_and:         alu_op = 3'b010;
          op_or:          alu_op = 3'b011;
          default:        alu_op = 3'b000;
        endcase
        if (op_addi || op_ld || op_st) alu_src_imm = 1'b1;
        if (op_beq && alu_zero) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = op_st;
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = op_ld;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

  logic unused_ok;
  assign unused_ok = op_alu;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_cpu_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        mem_ack;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic        alu_src_imm, reg_we, wb_sel, halted, fault;
  logic [2:0]  state_o;
  logic [15:0] instr_count;

  cpu_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .fault(fault), .state_o(state_o),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl field order: req we asel irwe pcwe | pc_src | alu_op | imm rwe wbs hlt flt
  localparam logic [14:0] Z     = 15'b0_0_0_0_0_00_000_0_0_0_0_0;
  localparam logic [14:0] F_W   = 15'b1_0_0_0_0_00_000_0_0_0_0_0;
  localparam logic [14:0] F_A   = 15'b1_0_0_1_1_00_000_0_0_0_0_0;
  localparam logic [14:0] D_J   = 15'b0_0_0_0_1_10_000_0_0_0_0_0;
  localparam logic [14:0] E_SUB = 15'b0_0_0_0_0_00_001_0_0_0_0_0;
  localparam logic [14:0] E_AND = 15'b0_0_0_0_0_00_010_0_0_0_0_0;
  localparam logic [14:0] E_OR  = 15'b0_0_0_0_0_00_011_0_0_0_0_0;
  localparam logic [14:0] E_IMM = 15'b0_0_0_0_0_00_000_1_0_0_0_0;
  localparam logic [14:0] E_BT  = 15'b0_0_0_0_1_01_001_0_0_0_0_0;
  localparam logic [14:0] M_LD  = 15'b1_0_1_0_0_00_000_0_0_0_0_0;
  localparam logic [14:0] M_ST  = 15'b1_1_1_0_0_00_000_0_0_0_0_0;
  localparam logic [14:0] W_AL  = 15'b0_0_0_0_0_00_000_0_1_0_0_0;
  localparam logic [14:0] W_LD  = 15'b0_0_0_0_0_00_000_0_1_1_0_0;
  localparam logic [14:0] C_H   = 15'b0_0_0_0_0_00_000_0_0_0_1_0;
  localparam logic [14:0] C_F   = 15'b0_0_0_0_0_00_000_0_0_0_0_1;

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic [14:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = q.pop_front();
      act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_op,
             alu_src_imm, reg_we, wb_sel, halted, fault};
      n_cmp++;
      if (state_o !== e.st || act !== e.ctl || instr_count !== e.cnt) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%0d ctl=%b cnt=%0d, want st=%0d ctl=%b cnt=%0d",
                 e.id, state_o, act, instr_count, e.st, e.ctl, e.cnt);
      end
    end
  end

  task automatic expect_now(input logic [2:0] st, input logic [14:0] c,
                            input logic [15:0] n);
    exp_t e;
    e.id  = n_push;
    e.st  = st;
    e.ctl = c;
    e.cnt = n;
    n_push++;
    q.push_back(e);
  endtask

  // Called at posedge+1: drive this cycle's inputs and expected outputs.
  task automatic step(input logic s, input logic [3:0] op, input logic ack,
                      input logic z, input logic [2:0] st,
                      input logic [14:0] c, input logic [15:0] n);
    start    = s;
    opcode   = op;
    mem_ack  = ack;
    alu_zero = z;
    expect_now(st, c, n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start   = 1'b0;
    mem_ack = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    opcode   = 4'h0;
    alu_zero = 1'b0;
    mem_ack  = 1'b0;
    expect_now(3'd0, Z, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD, zero-wait
    step(1, 4'h1, 0, 0, 3'd0, Z, 0);
    step(0, 4'h1, 1, 0, 3'd1, F_A, 0);
    step(0, 4'h1, 0, 0, 3'd2, Z, 0);
    step(0, 4'h1, 0, 0, 3'd3, Z, 0);
    step(0, 4'h1, 0, 0, 3'd5, W_AL, 0);
    // LD, one fetch wait, three MEM wait cycles
    step(0, 4'h6, 0, 0, 3'd1, F_W, 1);
    step(0, 4'h6, 1, 0, 3'd1, F_A, 1);
    step(0, 4'h6, 0, 0, 3'd2, Z, 1);
    step(0, 4'h6, 0, 0, 3'd3, E_IMM, 1);
    for (int i = 0; i < 3; i++) step(0, 4'h6, 0, 0, 3'd4, M_LD, 1);
    step(0, 4'h6, 1, 0, 3'd4, M_LD, 1);
    step(0, 4'h6, 0, 0, 3'd5, W_LD, 1);
    // BEQ taken, then not taken
    step(0, 4'h8, 1, 0, 3'd1, F_A, 2);
    step(0, 4'h8, 0, 1, 3'd2, Z, 2);
    step(0, 4'h8, 0, 1, 3'd3, E_BT, 2);
    step(0, 4'h8, 1, 0, 3'd1, F_A, 3);
    step(0, 4'h8, 0, 0, 3'd2, Z, 3);
    step(0, 4'h8, 0, 0, 3'd3, E_SUB, 3);
    // SUB / AND / OR / ADDI
    step(0, 4'h2, 1, 0, 3'd1, F_A, 4);
    step(0, 4'h2, 0, 0, 3'd2, Z, 4);
    step(0, 4'h2, 0, 0, 3'd3, E_SUB, 4);
    step(0, 4'h2, 0, 0, 3'd5, W_AL, 4);
    step(0, 4'h3, 1, 0, 3'd1, F_A, 5);
    step(0, 4'h3, 0, 0, 3'd2, Z, 5);
    step(0, 4'h3, 0, 0, 3'd3, E_AND, 5);
    step(0, 4'h3, 0, 0, 3'd5, W_AL, 5);
    step(0, 4'h4, 1, 0, 3'd1, F_A, 6);
    step(0, 4'h4, 0, 0, 3'd2, Z, 6);
    step(0, 4'h4, 0, 0, 3'd3, E_OR, 6);
    step(0, 4'h4, 0, 0, 3'd5, W_AL, 6);
    step(0, 4'h5, 1, 0, 3'd1, F_A, 7);
    step(0, 4'h5, 0, 0, 3'd2, Z, 7);
    step(0, 4'h5, 0, 0, 3'd3, E_IMM, 7);
    step(0, 4'h5, 0, 0, 3'd5, W_AL, 7);
    // ST; stray start/ack in DECODE ignored
    step(0, 4'h7, 1, 0, 3'd1, F_A, 8);
    step(1, 4'h7, 1, 0, 3'd2, Z, 8);
    step(0, 4'h7, 0, 0, 3'd3, E_IMM, 8);
    step(0, 4'h7, 1, 0, 3'd4, M_ST, 8);
    // JMP with stray ack in DECODE, then NOP
    step(0, 4'h9, 1, 0, 3'd1, F_A, 9);
    step(0, 4'h9, 1, 0, 3'd2, D_J, 9);
    step(0, 4'h0, 1, 0, 3'd1, F_A, 10);
    step(0, 4'h0, 0, 0, 3'd2, Z, 10);
    // ack on the 16th wait cycle still wins
    for (int i = 0; i < 15; i++) step(0, 4'h0, 0, 0, 3'd1, F_W, 11);
    step(0, 4'h0, 1, 0, 3'd1, F_A, 11);
    step(0, 4'h0, 0, 0, 3'd2, Z, 11);
    // no ack: FAULT after exactly 16 request cycles
    for (int i = 0; i < 16; i++) step(0, 4'h0, 0, 0, 3'd1, F_W, 12);
    step(0, 4'h0, 0, 0, 3'd7, C_F, 12);
    step(1, 4'h0, 0, 0, 3'd7, C_F, 12);

    // HLT, start ignored afterwards
    do_reset();
    step(1, 4'hF, 0, 0, 3'd0, Z, 0);
    step(0, 4'hF, 1, 0, 3'd1, F_A, 0);
    step(0, 4'hF, 0, 0, 3'd2, Z, 0);
    step(0, 4'hF, 0, 0, 3'd6, C_H, 1);
    step(1, 4'hF, 0, 0, 3'd6, C_H, 1);
    step(0, 4'hF, 0, 0, 3'd6, C_H, 1);
    // illegal opcode, no retire
    do_reset();
    step(1, 4'hB, 0, 0, 3'd0, Z, 0);
    step(0, 4'hB, 1, 0, 3'd1, F_A, 0);
    step(0, 4'hB, 0, 0, 3'd2, Z, 0);
    step(0, 4'hB, 0, 0, 3'd7, C_F, 0);
    step(0, 4'hB, 0, 0, 3'd7, C_F, 0);

    // async reset in the middle of a MEM wait
    do_reset();
    step(1, 4'h0, 0, 0, 3'd0, Z, 0);
    step(0, 4'h0, 1, 0, 3'd1, F_A, 0);
    step(0, 4'h0, 0, 0, 3'd2, Z, 0);
    step(0, 4'h6, 1, 0, 3'd1, F_A, 1);
    step(0, 4'h6, 0, 0, 3'd2, Z, 1);
    step(0, 4'h6, 0, 0, 3'd3, E_IMM, 1);
    step(0, 4'h6, 0, 0, 3'd4, M_LD, 1);
    mem_ack = 1'b0;
    #1;
    rst = 1'b1;
    expect_now(3'd0, Z, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 4'h6, 0, 0, 3'd0, Z, 0);
    step(1, 4'h6, 0, 0, 3'd0, Z, 0);
    step(0, 4'h6, 0, 0, 3'd1, F_W, 0);
    step(0, 4'h6, 1, 0, 3'd1, F_A, 0);
    start   = 1'b0;
    mem_ack = 1'b0;

    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
